sync_fifo_flex: RTL and testbench
=================================

// Module: sync_fifo_flex
// PURPOSE
//   Single-clock FIFO for same-domain buffering between producer/consumer blocks.
//   Parametrised successor to the dual-clock FIFO: no pointer synchronisers.
//   Adds a fill-level count, programmable almost-full/almost-empty thresholds,
//   selectable standard/first-word-fall-through (FWFT) read mode and sticky error flags.
// PARAMETERS
//   DATA_WIDTH  8  word width in bits
//   ADRRSIZE    3  address bits; DEPTH = 2**ADRRSIZE entries
//   AFULL_TH    6  walmost_full asserts when count >= AFULL_TH (legal 1..DEPTH)
//   AEMPTY_TH   1  ralmost_empty asserts when count <= AEMPTY_TH (legal 0..DEPTH-1)
//   FWFT        0  0 = registered read (1-cycle latency); 1 = head word visible on rdata
// PORTS
//   clk            in   1             clock, all logic on rising edge
//   rst_n          in   1             asynchronous active-low reset
//   winc           in   1             write request
//   wdata          in   DATA_WIDTH    write data
//   rinc           in   1             read/pop request
//   err_clr        in   1             synchronous clear of overflow/underflow
//   rdata          out  DATA_WIDTH    read data
//   wfull          out  1             FIFO holds DEPTH words
//   rempty         out  1             FIFO holds 0 words
//   walmost_full   out  1             count >= AFULL_TH
//   ralmost_empty  out  1             count <= AEMPTY_TH
//   count          out  ADRRSIZE+1    words currently stored, 0..DEPTH
//   overflow       out  1             sticky: write attempted while full
//   underflow      out  1             sticky: read attempted while empty
// BEHAVIOUR
//   - Clock is clk. Reset is asynchronous, active-low, on rst_n.
//   - Reset (async assert, sync-to-clk release): wptr=rptr=0, count=0, rempty=1,
//     wfull=0, ralmost_empty=1, walmost_full=0, overflow=underflow=0, rdata=0.
//     Memory array is not reset. Reset mid-operation discards all stored words.
//   - Pointers wptr/rptr are ADRRSIZE+1-bit binary. Low ADRRSIZE bits address memory.
//     MSB is the wrap bit. Pointers wrap modulo 2**(ADRRSIZE+1).
//   - empty: wptr==rptr. full: MSBs differ and low bits equal.
//     count = wptr-rptr, mod 2**(ADRRSIZE+1).
//   - Write accepted (wen) iff winc && !wfull. mem[waddr]<=wdata and wptr++ on that edge.
//   - Read accepted (ren) iff rinc && !rempty. rptr++ on that edge.
//   - wen/ren use the current-cycle flags only.
//     Full FIFO with winc&rinc: read accepted, write rejected, overflow set.
//     Empty FIFO with winc&rinc: write accepted, read rejected, underflow set. No write-through.
//   - Both accepted: count unchanged, both pointers advance.
//     wen only: count+1. ren only: count-1.
//   - All flags and count are registered/derived from registered pointers.
//     They update on the same edge as the pointer change. No extra latency.
//   - FWFT=0: rdata <= mem[raddr] on the ren edge, i.e. valid 1 cycle after rinc.
//     rdata holds its value otherwise.
//   - FWFT=1: rdata = mem[raddr] combinationally. It is valid whenever rempty==0.
//     rinc pops the word. rdata is don't-care while rempty==1.
//   - overflow <= 1 when winc && wfull. underflow <= 1 when rinc && rempty.
//     Both cleared by err_clr. A set event in the same cycle as err_clr wins.
//   - Out-of-range AFULL_TH/AEMPTY_TH: elaboration error via generate-time check.
// TESTING
//   1 Reset: rst_n=0 mid-stream -> count=0, rempty=1, wfull=0, ralmost_empty=1,
//     flags 0 immediately, without a clock edge.
//   2 Fill (defaults, DEPTH=8): write 0x01..0x08 -> walmost_full at count=6,
//     wfull at count=8. 9th winc -> ignored, overflow=1, count stays 8.
//   3 Drain, FWFT=0: 8 rinc -> rdata 0x01..0x08, each 1 cycle after its rinc.
//     rempty=1 after 8th. Extra rinc -> underflow=1, rdata holds 0x08.
//   4 Simultaneous: count=4, winc&rinc for 10 cycles -> count stays 4.
//     Pointers wrap past 8. Data order preserved.
//   5 Edge cases: full with winc&rinc -> count 7, overflow=1.
//     Empty with winc&rinc -> count 1, underflow=1. err_clr -> both 0 next cycle.
//   6 FWFT=1: write 0xA5 into empty -> rdata=0xA5 and rempty=0 the next cycle,
//     with no rinc. rinc -> rempty=1.

Source files
------------

// File: rtl/sync_fifo_flex_if.sv
// Bus bundle for sync_fifo_flex: producer/consumer handshake, data and status.
interface sync_fifo_flex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADRRSIZE   = 3
);
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rinc;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wfull;
  logic                  rempty;
  logic                  walmost_full;
  logic                  ralmost_empty;
  logic [ADRRSIZE:0]     count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output winc, wdata, rinc, err_clr,
    input  rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc, err_clr,
    output rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds,
// standard or first-word-fall-through read and sticky overflow/underflow.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int ADRRSIZE   = 3,
  parameter int AFULL_TH   = 6,
  parameter int AEMPTY_TH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sync_fifo_flex_if.slave      bus
);
  localparam int DEPTH = 2**ADRRSIZE;
  localparam logic [ADRRSIZE:0] AF_LVL = AFULL_TH[ADRRSIZE:0];
  localparam logic [ADRRSIZE:0] AE_LVL = AEMPTY_TH[ADRRSIZE:0];

  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $fatal(1, "sync_fifo_flex: AFULL_TH out of range 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $fatal(1, "sync_fifo_flex: AEMPTY_TH out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADRRSIZE:0]     wptr;
  logic [ADRRSIZE:0]     rptr;
  logic [ADRRSIZE:0]     fill;
  logic                  full;
  logic                  empty;
  logic                  wen;
  logic                  ren;
  logic                  ovf;
  logic                  unf;
  logic [ADRRSIZE-1:0]   waddr;
  logic [ADRRSIZE-1:0]   raddr;

  assign waddr = wptr[ADRRSIZE-1:0];
  assign raddr = rptr[ADRRSIZE-1:0];
  assign empty = (wptr == rptr);
  assign full  = (wptr[ADRRSIZE] != rptr[ADRRSIZE]) && (waddr == raddr);
  assign fill  = wptr - rptr;
  assign wen   = bus.winc && !full;
  assign ren   = bus.rinc && !empty;

  assign bus.wfull         = full;
  assign bus.rempty        = empty;
  assign bus.count         = fill;
  assign bus.walmost_full  = (fill >= AF_LVL);
  assign bus.ralmost_empty = (fill <= AE_LVL);
  assign bus.overflow      = ovf;
  assign bus.underflow     = unf;

  // Pointer registers; status is decoded from these so it moves on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wen) wptr <= wptr + 1'b1;
      if (ren) rptr <= rptr + 1'b1;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= bus.wdata;
  end

  // Sticky error flags; a set event in the clearing cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (bus.winc && full)      ovf <= 1'b1;
      else if (bus.err_clr)      ovf <= 1'b0;
      if (bus.rinc && empty)     unf <= 1'b1;
      else if (bus.err_clr)      unf <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.rdata = mem[raddr];
  end else begin : g_regread
    logic [DATA_WIDTH-1:0] rdata_q;
    // Registered read: capture the head word on the accepted pop edge, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   rdata_q <= '0;
      else if (ren) rdata_q <= mem[raddr];
    end
    assign bus.rdata = rdata_q;
  end
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Randomised and directed bench for sync_fifo_flex; one standard-read and one
// FWFT instance share stimulus and a queue-based reference model.
module tb_sync_fifo_flex;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_flex_if #(.DATA_WIDTH(DW), .ADRRSIZE(AW)) bus0 ();
  sync_fifo_flex_if #(.DATA_WIDTH(DW), .ADRRSIZE(AW)) bus1 ();

  sync_fifo_flex #(.DATA_WIDTH(DW), .ADRRSIZE(AW), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(0))
    u_std (.clk(clk), .rst_n(rst_n), .bus(bus0));
  sync_fifo_flex #(.DATA_WIDTH(DW), .ADRRSIZE(AW), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1))
    u_fwft (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata = '0;
  logic          m_ovf   = 1'b0;
  logic          m_unf   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int unsigned n;
    n = q.size();
    check_eq("count",         32'(bus0.count),         32'(n));
    check_eq("rempty",        32'(bus0.rempty),        32'(n == 0));
    check_eq("wfull",         32'(bus0.wfull),         32'(n == DEPTH));
    check_eq("walmost_full",  32'(bus0.walmost_full),  32'(n >= 6));
    check_eq("ralmost_empty", 32'(bus0.ralmost_empty), 32'(n <= 1));
    check_eq("overflow",      32'(bus0.overflow),      32'(m_ovf));
    check_eq("underflow",     32'(bus0.underflow),     32'(m_unf));
    check_eq("rdata_std",     32'(bus0.rdata),         32'(m_rdata));
    check_eq("fwft_count",    32'(bus1.count),         32'(n));
    check_eq("fwft_rempty",   32'(bus1.rempty),        32'(n == 0));
    if (n != 0) check_eq("fwft_rdata", 32'(bus1.rdata), 32'(q[0]));
  endtask

  // One clock of stimulus: drive at the falling edge, update the model at the
  // rising edge using pre-edge occupancy, then compare shortly after.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic ec);
    logic was_full, was_empty;
    @(negedge clk);
    bus0.winc = w; bus0.wdata = d; bus0.rinc = r; bus0.err_clr = ec;
    bus1.winc = w; bus1.wdata = d; bus1.rinc = r; bus1.err_clr = ec;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (r && !was_empty) m_rdata = q.pop_front();
    if (w && !was_full)  q.push_back(d);
    if (w && was_full)   m_ovf = 1'b1;
    else if (ec)         m_ovf = 1'b0;
    if (r && was_empty)  m_unf = 1'b1;
    else if (ec)         m_unf = 1'b0;
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    bus0.winc = 1'b0; bus0.wdata = '0; bus0.rinc = 1'b0; bus0.err_clr = 1'b0;
    bus1.winc = 1'b0; bus1.wdata = '0; bus1.rinc = 1'b0; bus1.err_clr = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear with no clock.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    idle_inputs();
    q.delete();
    m_rdata = '0; m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with 1..8, then one rejected write.
    for (int i = 1; i <= 8; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    check_eq("fill_count8", 32'(bus0.count), 32'd8);
    cyc(1'b1, 8'h09, 1'b0, 1'b0);
    check_eq("fill_ovf", 32'(bus0.overflow), 32'd1);

    // Drain; extra pop sets underflow and rdata holds the last word.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      check_eq("drain_word", 32'(bus0.rdata), 32'(i));
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    check_eq("drain_hold", 32'(bus0.rdata), 32'h08);
    check_eq("drain_unf",  32'(bus0.underflow), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Steady occupancy of 4 with simultaneous push/pop, pointers wrap.
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, DW'(8'h50 + i), 1'b1, 1'b0);
    check_eq("simul_count", 32'(bus0.count), 32'd4);

    // Full with push+pop: pop wins, overflow set.
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    check_eq("full_both_count", 32'(bus0.count), 32'd7);
    for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    // Empty with push+pop: push wins, underflow set, no write-through.
    cyc(1'b1, 8'h33, 1'b1, 1'b0);
    check_eq("empty_both_count", 32'(bus0.count), 32'd1);
    check_eq("empty_both_unf",   32'(bus0.underflow), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check_eq("clr_ovf", 32'(bus0.overflow), 32'd0);
    check_eq("clr_unf", 32'(bus0.underflow), 32'd0);
    // Set beats clear in the same cycle.
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    check_eq("set_wins_unf", 32'(bus0.underflow), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // FWFT: word visible the cycle after the write, with no pop.
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    check_eq("fwft_a5",     32'(bus1.rdata),  32'hA5);
    check_eq("fwft_nempty", 32'(bus1.rempty), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check_eq("fwft_popped", 32'(bus1.rempty), 32'd1);

    // Reset mid-stream.
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'($urandom), 1'b0, 1'b0);
    mid_reset();

    // Random traffic with a couple of phases of write/read bias.
    for (int i = 0; i < 600; i++) begin
      logic w, r, ec;
      int unsigned bias;
      bias = (i / 100) % 3;
      w  = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
      r  = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
      ec = ($urandom_range(0, 19) == 0);
      cyc(w, DW'($urandom), r, ec);
      if (i == 350) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
